// File: rtl/regfile_pkg.sv
// Types and constants shared by the writeback arbiter and the 32x64 register file.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int NUM_SRC  = 3;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer-side valid/ready channels and the two register-file write ports.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              src1_valid, src2_valid, src3_valid;
  logic [ADDR_W-1:0] src1_addr,  src2_addr,  src3_addr;
  logic [DATA_W-1:0] src1_data,  src2_data,  src3_data;
  logic              src1_ready, src2_ready, src3_ready;
  logic [ADDR_W-1:0] write_port_1, write_port_2;
  logic [DATA_W-1:0] write_data_1, write_data_2;

  modport slave (
    input  src1_valid, src2_valid, src3_valid,
    input  src1_addr,  src2_addr,  src3_addr,
    input  src1_data,  src2_data,  src3_data,
    output src1_ready, src2_ready, src3_ready,
    output write_port_1, write_port_2, write_data_1, write_data_2
  );

  modport master (
    output src1_valid, src2_valid, src3_valid,
    output src1_addr,  src2_addr,  src3_addr,
    output src1_data,  src2_data,  src3_data,
    input  src1_ready, src2_ready, src3_ready,
    input  write_port_1, write_port_2, write_data_1, write_data_2
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry FIFO of writeback requests; push and pop together are legal when full.
module wb_fifo2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  wb_req_t    i_din,
  output wb_req_t    o_head,
  output logic [1:0] o_count
);

  wb_req_t    r_mem [2];
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_pop, w_do_push, w_wr_ptr;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);
  // When full, the write slot is the one being popped this same edge.
  assign w_wr_ptr  = r_rd_ptr ^ (r_count == 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; r_count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Three-producer writeback arbiter feeding two register-file write ports.
// Optional stall counter port enabled by defining WB_STALL_CNT_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int AGE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]          stall_count
`endif
);

  localparam int AGE_W = 4;

  logic [NUM_SRC-1:0] w_valid, w_ready, w_push, w_head_valid, w_urgent, w_grant;
  wb_req_t            w_din   [NUM_SRC];
  wb_req_t            w_head  [NUM_SRC];
  logic [1:0]         w_count [NUM_SRC];

  logic               w_g1_vld, w_g2_vld;
  logic [1:0]         w_g1_idx, w_g2_idx;

  logic [ADDR_W-1:0]  r_wp1, r_wp2;
  logic [DATA_W-1:0]  r_wd1, r_wd2;

  assign w_valid = {wb.src3_valid, wb.src2_valid, wb.src1_valid};
  assign w_din[0] = {wb.src1_addr, wb.src1_data};
  assign w_din[1] = {wb.src2_addr, wb.src2_data};
  assign w_din[2] = {wb.src3_addr, wb.src3_data};

  assign wb.src1_ready = w_ready[0];
  assign wb.src2_ready = w_ready[1];
  assign wb.src3_ready = w_ready[2];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [AGE_W-1:0] r_age;

    assign w_ready[i]      = !reset && (w_count[i] != 2'd2);
    // Writes to r0 complete the handshake but never enter the queue.
    assign w_push[i]       = w_valid[i] && w_ready[i] && (w_din[i].addr != ZERO_REG);
    assign w_head_valid[i] = (w_count[i] != 2'd0);
    assign w_urgent[i]     = w_head_valid[i] && (r_age == AGE_W'(AGE_LIMIT));

    wb_fifo2 u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[i]),
      .i_pop   (w_grant[i]),
      .i_din   (w_din[i]),
      .o_head  (w_head[i]),
      .o_count (w_count[i])
    );

    always_ff @(posedge clk) begin
      if (reset || !w_head_valid[i] || w_grant[i]) r_age <= '0;
      else if (r_age != AGE_W'(AGE_LIMIT))        r_age <= r_age + 1'b1;
    end
  end

  // Pass 0 scans urgent heads, pass 1 the rest; lower source number wins within a pass.
  always_comb begin
    // NOTE: blocking assignments here build a priority chain; every output gets a default first.
    w_g1_vld = 1'b0;
    w_g1_idx = 2'd0;
    w_g2_vld = 1'b0;
    w_g2_idx = 2'd0;
    w_grant  = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_g1_vld && w_head_valid[i] && (w_urgent[i] == (p == 0))) begin
          w_g1_vld = 1'b1;
          w_g1_idx = 2'(i);
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_g1_vld && !w_g2_vld && w_head_valid[i] && (w_urgent[i] == (p == 0)) &&
            (2'(i) != w_g1_idx) && (w_head[i].addr != w_head[w_g1_idx].addr)) begin
          w_g2_vld = 1'b1;
          w_g2_idx = 2'(i);
        end
      end
    end
    if (w_g1_vld) w_grant[w_g1_idx] = 1'b1;
    if (w_g2_vld) w_grant[w_g2_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp1 <= ZERO_REG;
      r_wd1 <= '0;
      r_wp2 <= ZERO_REG;
      r_wd2 <= '0;
    end else begin
      r_wp1 <= w_g1_vld ? w_head[w_g1_idx].addr : ZERO_REG;
      r_wd1 <= w_g1_vld ? w_head[w_g1_idx].data : '0;
      r_wp2 <= w_g2_vld ? w_head[w_g2_idx].addr : ZERO_REG;
      r_wd2 <= w_g2_vld ? w_head[w_g2_idx].data : '0;
    end
  end

  assign wb.write_port_1 = r_wp1;
  assign wb.write_data_1 = r_wd1;
  assign wb.write_port_2 = r_wp2;
  assign wb.write_data_2 = r_wd2;

`ifdef WB_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk) begin
    if (reset) r_stall <= '0;
    else if (((w_head_valid & ~w_grant) != '0) && (r_stall != '1)) r_stall <= r_stall + 32'd1;
  end

  assign stall_count = r_stall;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (stall counter checked when WB_STALL_CNT_EN is defined).
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct packed {
    logic [4:0]  p1;
    logic [63:0] d1;
    logic [4:0]  p2;
    logic [63:0] d2;
  } out_t;

  typedef struct packed {
    logic [2:0]       v;
    logic [2:0][4:0]  a;
    logic [2:0][63:0] d;
    out_t             e1;
    out_t             e2;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if wb ();

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  regfile_wb_arbiter #(.AGE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [4:0] a, input logic [63:0] d);
    case (s)
      0: begin wb.src1_valid = v; wb.src1_addr = a; wb.src1_data = d; end
      1: begin wb.src2_valid = v; wb.src2_addr = a; wb.src2_data = d; end
      default: begin wb.src3_valid = v; wb.src3_addr = a; wb.src3_data = d; end
    endcase
  endtask

  task automatic idle_all();
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 5'd0, 64'd0);
  endtask

  function automatic out_t outs();
    return '{p1: wb.write_port_1, d1: wb.write_data_1, p2: wb.write_port_2, d2: wb.write_data_2};
  endfunction

  function automatic logic [2:0] rdy();
    return {wb.src3_ready, wb.src2_ready, wb.src1_ready};
  endfunction

  function automatic out_t mo(input logic [4:0] p1, input logic [63:0] d1, input logic [4:0] p2, input logic [63:0] d2);
    return '{p1: p1, d1: d1, p2: p2, d2: d2};
  endfunction

  function automatic vec_t mv(input logic [2:0] v,
                              input logic [4:0] a1, input logic [63:0] d1,
                              input logic [4:0] a2, input logic [63:0] d2,
                              input logic [4:0] a3, input logic [63:0] d3,
                              input out_t e1, input out_t e2);
    vec_t r;
    r.v = v;
    r.a = {a3, a2, a1};
    r.d = {d3, d2, d1};
    r.e1 = e1;
    r.e2 = e2;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    out_t zero_o;
    zero_o = '0;

    vecs[0] = mv(3'b011, 5'd5, 64'hA, 5'd6, 64'hB, 5'd0, 64'h0,
                 mo(5'd5, 64'hA, 5'd6, 64'hB), zero_o);
    vecs[1] = mv(3'b011, 5'd7, 64'h11, 5'd7, 64'h22, 5'd0, 64'h0,
                 mo(5'd7, 64'h11, 5'd0, 64'h0), mo(5'd7, 64'h22, 5'd0, 64'h0));
    vecs[2] = mv(3'b111, 5'd1, 64'h101, 5'd2, 64'h202, 5'd3, 64'h303,
                 mo(5'd1, 64'h101, 5'd2, 64'h202), mo(5'd3, 64'h303, 5'd0, 64'h0));
    vecs[3] = mv(3'b100, 5'd0, 64'h0, 5'd0, 64'h0, 5'd9, 64'h909,
                 mo(5'd9, 64'h909, 5'd0, 64'h0), zero_o);
    vecs[4] = mv(3'b110, 5'd0, 64'h0, 5'd4, 64'h44, 5'd4, 64'h55,
                 mo(5'd4, 64'h44, 5'd0, 64'h0), mo(5'd4, 64'h55, 5'd0, 64'h0));
    vecs[5] = mv(3'b011, 5'd0, 64'hDEAD, 5'd8, 64'h88, 5'd0, 64'h0,
                 mo(5'd8, 64'h88, 5'd0, 64'h0), zero_o);
    vecs[6] = mv(3'b111, 5'd10, 64'hA1, 5'd10, 64'hA2, 5'd11, 64'hB3,
                 mo(5'd10, 64'hA1, 5'd11, 64'hB3), mo(5'd10, 64'hA2, 5'd0, 64'h0));
    vecs[7] = mv(3'b101, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'h0, 5'd31, 64'h1,
                 mo(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'h0), mo(5'd31, 64'h1, 5'd0, 64'h0));

    // Reset state
    idle_all();
    reset = 1'b1;
    #1;
    check("ready_in_reset", 160'(rdy()), 160'(3'b000));
    step();
    check("outs_after_reset", 160'(outs()), 160'(zero_o));
    reset = 1'b0;
    #1;
    check("ready_after_reset", 160'(rdy()), 160'(3'b111));

    // Table: single-cycle injection, then two cycles of expected port activity
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 3; s++) set_src(s, vecs[k].v[s], vecs[k].a[s], vecs[k].d[s]);
      step();
      idle_all();
      step();
      check($sformatf("vec%0d_first", k), 160'(outs()), 160'(vecs[k].e1));
      check($sformatf("vec%0d_ready", k), 160'(rdy()), 160'(3'b111));
      step();
      check($sformatf("vec%0d_second", k), 160'(outs()), 160'(vecs[k].e2));
      step();
      step();
    end

    // Starvation: src3 waits until its age saturates, then wins port 1
    for (int e = 0; e < 10; e++) begin
      set_src(0, 1'b1, 5'd1, 64'h1000 + 64'(e));
      set_src(1, 1'b1, 5'd2, 64'h2000 + 64'(e));
      set_src(2, 1'b1, 5'd3, 64'h3000 + 64'(e));
      step();
      if (e >= 1 && e <= 8) begin
        check($sformatf("starve_e%0d_ports", e), 160'(outs()),
              160'(mo(5'd1, 64'h1000 + 64'(e - 1), 5'd2, 64'h2000 + 64'(e - 1))));
        check($sformatf("starve_e%0d_ready", e), 160'({wb.src3_ready, wb.src1_ready}), 160'(2'b01));
      end else if (e == 9) begin
        check("starve_urgent_ports", 160'(outs()), 160'(mo(5'd3, 64'h3000, 5'd1, 64'h1008)));
        check("starve_ready3_back", 160'(wb.src3_ready), 160'(1'b1));
      end
    end
    idle_all();
    for (int c = 0; c < 30; c++) step();
    check("starve_drained_ports", 160'(outs()), 160'(zero_o));
    check("starve_drained_ready", 160'(rdy()), 160'(3'b111));

    // Writes to r0 are accepted and dropped
    for (int c = 0; c < 10; c++) begin
      set_src(0, 1'b1, 5'd0, 64'hBAD0 + 64'(c));
      step();
      check($sformatf("r0_c%0d", c), 160'({wb.src1_ready, wb.write_port_1, wb.write_port_2}), 160'({1'b1, 5'd0, 5'd0}));
    end
    idle_all();
    step();

    // Mid-stream reset with FIFO2 full
    set_src(0, 1'b1, 5'd7, 64'h71);
    set_src(1, 1'b1, 5'd7, 64'h72);
    step();
    step();
    check("fill_ready2_low", 160'(wb.src2_ready), 160'(1'b0));
    step();
    idle_all();
    reset = 1'b1;
    #1;
    check("midreset_ready_low", 160'(rdy()), 160'(3'b000));
    step();
    check("midreset_outs_zero", 160'(outs()), 160'(zero_o));
    reset = 1'b0;
    #1;
    check("midreset_ready_high", 160'(rdy()), 160'(3'b111));
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("no_stale_c%0d", c), 160'(outs()), 160'(zero_o));
    end

`ifdef WB_STALL_CNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_src(0, 1'b1, 5'd1, 64'h1);
    set_src(1, 1'b1, 5'd2, 64'h2);
    set_src(2, 1'b1, 5'd3, 64'h3);
    for (int c = 0; c < 5; c++) step();
    idle_all();
    step();
    check("stall_count_5", 160'(stall_count), 160'(32'd5));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("stall_count_reset", 160'(stall_count), 160'(32'd0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
